// File: rtl/conv_pkg.sv
// conv_pkg: shared pixel-pipeline constants for the line buffer and convolution.
// Defaults for colour depth, line width, tap count and column address width.
package conv_pkg;

  localparam int CONV_COLORDEPTH  = 8;
  localparam int CONV_SCREENWIDTH = 1600;
  localparam int CONV_M_DEPTH     = 5;
  localparam int CONV_TAPS        = 5;

  function automatic int col_w(input int sw);
    return (sw > 1) ? $clog2(sw) : 1;
  endfunction

  localparam int CONV_COL_W = col_w(CONV_SCREENWIDTH);

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } conv_sync_t;

endpackage

// File: rtl/conv_line_buffer_if.sv
// conv_line_buffer_if: raster stream in, aligned column taps out.
// master drives the raster side, slave is the line buffer.
interface conv_line_buffer_if
  import conv_pkg::*;
#(
  parameter int COLORDEPTH = CONV_COLORDEPTH
);

  logic [COLORDEPTH-1:0] pix_i;
  logic                  dv_i;
  logic                  hs_i;
  logic                  vs_i;
  logic [COLORDEPTH-1:0] vect_out_0;
  logic [COLORDEPTH-1:0] vect_out_1;
  logic [COLORDEPTH-1:0] vect_out_2;
  logic [COLORDEPTH-1:0] vect_out_3;
  logic [COLORDEPTH-1:0] vect_out_4;
  logic                  dv_o;
  logic                  hs_o;
  logic                  vs_o;
  logic [2:0]            lines_valid_o;
  logic                  overflow_o;

  modport master (
    output pix_i, dv_i, hs_i, vs_i,
    input  vect_out_0, vect_out_1, vect_out_2,
    input  vect_out_3, vect_out_4,
    input  dv_o, hs_o, vs_o,
    input  lines_valid_o, overflow_o
  );

  modport slave (
    input  pix_i, dv_i, hs_i, vs_i,
    output vect_out_0, vect_out_1, vect_out_2,
    output vect_out_3, vect_out_4,
    output dv_o, hs_o, vs_o,
    output lines_valid_o, overflow_o
  );

endinterface

// File: rtl/line_ram.sv
// line_ram: simple dual-port line memory, one write and one registered read.
// Contents are never reset; stale data is masked by the consumer.
module line_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 1600,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: cascaded line memories giving a vertical pixel column.
// Build option CONV_LB_BORDER_REPLICATE_EN replicates the oldest valid row.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int COLORDEPTH  = CONV_COLORDEPTH,
  parameter int SCREENWIDTH = CONV_SCREENWIDTH,
  parameter int M_DEPTH     = CONV_M_DEPTH
) (
  input logic               clk,
  input logic               rst,
  conv_line_buffer_if.slave bus
);

  localparam int CW = col_w(SCREENWIDTH);
  localparam int NM = M_DEPTH - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SCREENWIDTH - 1);
  localparam logic [2:0] LV_MAX = 3'(M_DEPTH - 1);

  typedef logic [COLORDEPTH-1:0] px_t;

  px_t        pix_d;
  conv_sync_t sync_i, sync_d;
  logic [CW-1:0] col, col_d, col_eff;
  logic       full, xs_d, ovf;
  logic [2:0] lv;
  logic       vs_rise, dv_fall, full_eff;
  logic       excess, at_last, we;
  px_t        rd  [CONV_TAPS-1];
  px_t        row [CONV_TAPS];
  px_t        vo  [CONV_TAPS];

  assign sync_i   = '{dv: bus.dv_i, hs: bus.hs_i, vs: bus.vs_i};
  assign vs_rise  = bus.vs_i & ~sync_d.vs;
  assign dv_fall  = sync_d.dv & ~bus.dv_i;
  // A frame start overrides the running column for the same pixel
  assign col_eff  = vs_rise ? '0 : col;
  assign full_eff = full & ~vs_rise;
  assign excess   = bus.dv_i & full_eff;
  assign at_last  = col_eff == COL_LAST;
  assign we       = sync_d.dv & ~xs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_d  <= '0;
      sync_d <= '0;
      col    <= '0;
      col_d  <= '0;
      full   <= 1'b0;
      xs_d   <= 1'b0;
      ovf    <= 1'b0;
      lv     <= '0;
    end else begin
      pix_d  <= bus.pix_i;
      sync_d <= sync_i;
      col_d  <= col_eff;
      xs_d   <= excess;
      if (bus.dv_i) begin
        col  <= at_last ? col_eff : col_eff + 1'b1;
        full <= full_eff | at_last;
      end else if (dv_fall || vs_rise) begin
        col  <= '0;
        full <= 1'b0;
      end
      if (vs_rise)
        lv <= '0;
      else if (dv_fall && lv != LV_MAX)
        lv <= lv + 3'd1;
      if (vs_rise)
        ovf <= 1'b0;
      else if (excess)
        ovf <= 1'b1;
    end
  end

  for (genvar k = 0; k < CONV_TAPS - 1; k++) begin : g_tap
    if (k < NM) begin : g_ram
      line_ram #(
        .W    (COLORDEPTH),
        .DEPTH(SCREENWIDTH),
        .AW   (CW)
      ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(col_d),
        .wdata((k == 0) ? pix_d : rd[(k == 0) ? 0 : k - 1]),
        .re   (bus.dv_i),
        .raddr(col_eff),
        .rdata(rd[k])
      );
    end else begin : g_none
      assign rd[k] = '0;
    end
  end

`ifdef CONV_LB_BORDER_REPLICATE_EN
  px_t oldest;
`endif

  always_comb begin
    row[0] = pix_d;
    for (int k = 1; k < CONV_TAPS; k++)
      row[k] = rd[k-1];
`ifdef CONV_LB_BORDER_REPLICATE_EN
    oldest = row[0];
    for (int k = 1; k < CONV_TAPS; k++)
      if (3'(k) == lv) oldest = row[k];
`endif
    for (int k = 0; k < CONV_TAPS; k++) begin
      vo[k] = row[k];
      if (3'(k) > lv) begin
`ifdef CONV_LB_BORDER_REPLICATE_EN
        vo[k] = oldest;
`else
        vo[k] = '0;
`endif
      end
      if (k > 0 && xs_d) vo[k] = '0;
      if (!sync_d.dv) vo[k] = '0;
    end
  end

  assign bus.vect_out_0    = vo[0];
  assign bus.vect_out_1    = vo[1];
  assign bus.vect_out_2    = vo[2];
  assign bus.vect_out_3    = vo[3];
  assign bus.vect_out_4    = vo[4];
  assign bus.dv_o          = sync_d.dv;
  assign bus.hs_o          = sync_d.hs;
  assign bus.vs_o          = sync_d.vs;
  assign bus.lines_valid_o = lv;
  assign bus.overflow_o    = ovf;

endmodule
